// File: rtl/psram_port_arbiter_if.sv
// psram_port_arbiter_if: requester ports, response and PSRAM controller command/status bundle
interface psram_port_arbiter_if #(parameter int ADDR_WIDTH = 21);
  logic                  a_req, b_req, a_wr, b_wr;
  logic [ADDR_WIDTH-1:0] a_addr, b_addr;
  logic [15:0]           a_wdata, b_wdata;
  logic [1:0]            a_be, b_be;
  logic                  a_ack, b_ack, a_rvalid, b_rvalid, a_rerr, b_rerr;
  logic [15:0]           rdata;
  logic                  busy;
  logic                  mem_write_en, mem_read_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_data_in;
  logic                  mem_write_high_byte, mem_write_low_byte;
  logic                  mem_read_ack, mem_read_avail;
  logic [15:0]           mem_data_out;
  modport slave (
    input  a_req, b_req, a_wr, b_wr, a_addr, b_addr, a_wdata, b_wdata, a_be, b_be,
           mem_read_ack, mem_read_avail, mem_data_out,
    output a_ack, b_ack, a_rvalid, b_rvalid, a_rerr, b_rerr, rdata, busy,
           mem_write_en, mem_read_en, mem_addr, mem_data_in, mem_write_high_byte, mem_write_low_byte
  );
  modport master (
    output a_req, b_req, a_wr, b_wr, a_addr, b_addr, a_wdata, b_wdata, a_be, b_be,
           mem_read_ack, mem_read_avail, mem_data_out,
    input  a_ack, b_ack, a_rvalid, b_rvalid, a_rerr, b_rerr, rdata, busy,
           mem_write_en, mem_read_en, mem_addr, mem_data_in, mem_write_high_byte, mem_write_low_byte
  );
endinterface

// File: rtl/psram_port_arbiter.sv
// psram_port_arbiter: round-robin two-port arbiter/sequencer onto one PSRAM command stream,
// turning controller status edges into per-port read responses with a read timeout.
module psram_port_arbiter #(
  parameter int ADDR_WIDTH     = 21,
  parameter int WRITE_CYCLES   = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk_mem_85_9,
  input logic reset_n,
  psram_port_arbiter_if.slave bus
);
  localparam int CMAX = WRITE_CYCLES > TIMEOUT_CYCLES ? WRITE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WR_HOLD, RD_WAIT_ACK, RD_WAIT_AVAIL} state_t;
  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]            be_q, be_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  prev_ack_q, prev_avail_q;
  logic                  rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic                  ack_edge, avail_edge;
  assign ack_edge   = bus.mem_read_ack & ~prev_ack_q;
  assign avail_edge = bus.mem_read_avail & ~prev_avail_q;
  always_ff @(posedge clk_mem_85_9 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      cnt_q        <= '0;
      prev_ack_q   <= 1'b0;
      prev_avail_q <= 1'b0;
      rvalid_q     <= 1'b0;
      rerr_q       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      cnt_q        <= cnt_d;
      prev_ack_q   <= bus.mem_read_ack;
      prev_avail_q <= bus.mem_read_avail;
      rvalid_q     <= rvalid_d;
      rerr_q       <= rerr_d;
      rdata_q      <= rdata_d;
    end
  end
  // last_grant: 1 = port B; it also selects which port receives ack/rvalid
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    cnt_d        = cnt_q;
    rvalid_d     = 1'b0;
    rerr_d       = 1'b0;
    rdata_d      = rdata_q;
    case (state_q)
      IDLE: if (bus.a_req | bus.b_req) begin
        last_grant_d = bus.b_req & (~bus.a_req | ~last_grant_q);
        wr_d         = last_grant_d ? bus.b_wr : bus.a_wr;
        addr_d       = last_grant_d ? bus.b_addr : bus.a_addr;
        wdata_d      = last_grant_d ? bus.b_wdata : bus.a_wdata;
        be_d         = last_grant_d ? bus.b_be : bus.a_be;
        state_d      = ISSUE;
      end
      ISSUE: begin
        cnt_d   = wr_q ? CW'(WRITE_CYCLES - 1) : CW'(TIMEOUT_CYCLES - 1);
        state_d = wr_q ? WR_HOLD : RD_WAIT_ACK;
      end
      WR_HOLD: begin
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
        state_d = cnt_q == '0 ? IDLE : WR_HOLD;
      end
      default: begin
        // response is registered, so the wait state lingers one cycle while rvalid is out
        cnt_d = rvalid_q ? cnt_q : cnt_q - CW'(1);
        if (rvalid_q) state_d = IDLE;
        else if (state_q == RD_WAIT_AVAIL && avail_edge) begin
          rvalid_d = 1'b1;
          rdata_d  = bus.mem_data_out;
        end else if (cnt_q == CW'(1)) begin
          rvalid_d = 1'b1;
          rerr_d   = 1'b1;
          rdata_d  = '0;
        end else if (state_q == RD_WAIT_ACK && ack_edge) state_d = RD_WAIT_AVAIL;
      end
    endcase
  end
  always_comb begin
    bus.busy                = state_q != IDLE;
    bus.a_ack               = state_q == ISSUE && !last_grant_q;
    bus.b_ack               = state_q == ISSUE && last_grant_q;
    bus.mem_write_en        = state_q == ISSUE && wr_q;
    bus.mem_read_en         = state_q == ISSUE && !wr_q;
    bus.a_rvalid            = rvalid_q & ~last_grant_q;
    bus.b_rvalid            = rvalid_q & last_grant_q;
    bus.a_rerr              = rerr_q & ~last_grant_q;
    bus.b_rerr              = rerr_q & last_grant_q;
    bus.rdata               = rdata_q;
    bus.mem_addr            = addr_q;
    bus.mem_data_in         = wdata_q;
    bus.mem_write_high_byte = be_q[1];
    bus.mem_write_low_byte  = be_q[0];
  end
endmodule

// File: tb/tb_psram_port_arbiter.sv
// tb_psram_port_arbiter: directed checks of arbitration, write hold, read completion, timeout and reset
module tb_psram_port_arbiter;
  logic clk = 0, rst_n = 0;
  int total = 0, bad = 0;
  psram_port_arbiter_if #(.ADDR_WIDTH(21)) bus ();
  psram_port_arbiter #(.ADDR_WIDTH(21), .WRITE_CYCLES(12), .TIMEOUT_CYCLES(255)) dut (
    .clk_mem_85_9(clk), .reset_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] flags();
    return {bus.a_ack, bus.b_ack, bus.a_rvalid, bus.b_rvalid, bus.a_rerr, bus.b_rerr,
            bus.mem_write_en, bus.mem_read_en};
  endfunction
  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && bus.busy; i++) step();
    chk(tag, bus.busy, 0);
  endtask
  task automatic req(input logic b, input logic wr, input logic [20:0] addr, input logic [15:0] d);
    if (b) begin bus.b_req = 1; bus.b_wr = wr; bus.b_addr = addr; bus.b_wdata = d; bus.b_be = 2'b11; end
    else begin bus.a_req = 1; bus.a_wr = wr; bus.a_addr = addr; bus.a_wdata = d; bus.a_be = 2'b11; end
  endtask
  initial begin
    int n, rv, arv, k, g;
    logic [15:0] rd;
    logic re;
    logic [3:0] ord;
    bus.a_req = 0; bus.b_req = 0; bus.a_wr = 0; bus.b_wr = 0; bus.a_addr = 0; bus.b_addr = 0;
    bus.a_wdata = 0; bus.b_wdata = 0; bus.a_be = 0; bus.b_be = 0;
    bus.mem_read_ack = 0; bus.mem_read_avail = 0; bus.mem_data_out = 0;
    repeat (3) step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_flags", flags(), 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_rdata", bus.rdata, 0);
    rst_n = 1;
    step();
    // write from A
    req(0, 1, 21'h00010, 16'hBEEF);
    step();
    chk("wr_flags", flags(), 8'b1000_0010);
    chk("wr_addr", bus.mem_addr, 21'h00010);
    chk("wr_data", bus.mem_data_in, 16'hBEEF);
    chk("wr_be", {bus.mem_write_high_byte, bus.mem_write_low_byte}, 2'b11);
    bus.a_req = 0;
    n = 1; rv = 0;
    for (int i = 0; i < 50 && bus.busy; i++) begin
      step();
      if (bus.busy) n++;
      if (bus.a_rvalid | bus.b_rvalid) rv++;
    end
    chk("wr_busy_len", n, 13);
    chk("wr_no_rvalid", rv, 0);
    // read from B with ack at +5 and avail at +8
    req(1, 0, 21'h1FFFF, 16'h0);
    step();
    chk("rd_flags", flags(), 8'b0100_0001);
    chk("rd_addr", bus.mem_addr, 21'h1FFFF);
    bus.b_req = 0;
    rv = 0; arv = 0; k = 0; rd = 0; re = 1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bus.b_rvalid) begin rv++; k = i; rd = bus.rdata; re = bus.b_rerr; end
      if (bus.a_rvalid) arv++;
      if (i == 5) bus.mem_read_ack = 1;
      if (i == 8) begin bus.mem_read_avail = 1; bus.mem_data_out = 16'h1234; end
    end
    chk("rd_count", rv, 1);
    chk("rd_a_quiet", arv, 0);
    chk("rd_when", k, 9);
    chk("rd_data", rd, 16'h1234);
    chk("rd_err", re, 0);
    chk("rd_idle", bus.busy, 0);
    bus.mem_read_ack = 0; bus.mem_read_avail = 0;
    // both ports contend, each re-requesting after its ack
    req(0, 1, 21'h00100, 16'hAAAA);
    req(1, 1, 21'h00200, 16'h5555);
    g = 0; ord = 0;
    for (int c = 0; c < 200 && g < 4; c++) begin
      step();
      bus.a_req = 1; bus.b_req = 1;
      if (bus.a_ack) begin ord[g] = 0; g++; bus.a_req = 0; end
      else if (bus.b_ack) begin ord[g] = 1; g++; bus.b_req = 0; end
    end
    chk("rr_grants", g, 4);
    chk("rr_order", ord, 4'b1010);
    bus.a_req = 0; bus.b_req = 0;
    wait_idle("rr_idle");
    // read that never completes
    req(1, 0, 21'h00ABC, 16'h0);
    step();
    chk("to_ack", bus.b_ack, 1);
    bus.b_req = 0;
    k = 0; rd = 16'hFFFF; re = 0;
    for (int i = 1; i <= 300 && k == 0; i++) begin
      step();
      if (bus.b_rvalid) begin k = i; rd = bus.rdata; re = bus.b_rerr; end
    end
    chk("to_when", k, 255);
    chk("to_err", re, 1);
    chk("to_data", rd, 16'h0000);
    req(0, 1, 21'h00055, 16'h1111);
    k = 0;
    for (int i = 1; i <= 6 && k == 0; i++) begin
      step();
      if (bus.a_ack) k = i;
    end
    chk("to_next_ack", k, 2);
    chk("to_next_addr", bus.mem_addr, 21'h00055);
    bus.a_req = 0;
    wait_idle("to_idle");
    // reset during RD_WAIT_AVAIL, then a stale avail edge
    req(1, 0, 21'h00333, 16'h0);
    step();
    bus.b_req = 0;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 5) bus.mem_read_ack = 1;
    end
    chk("mr_busy", bus.busy, 1);
    rst_n = 0;
    #1;
    chk("mr_rst_busy", bus.busy, 0);
    chk("mr_rst_flags", flags(), 0);
    chk("mr_rst_addr", bus.mem_addr, 0);
    step();
    rst_n = 1;
    bus.mem_read_avail = 1; bus.mem_data_out = 16'hDEAD;
    rv = 0; n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.a_rvalid | bus.b_rvalid) rv++;
      if (bus.busy) n++;
    end
    chk("mr_no_rvalid", rv, 0);
    chk("mr_stay_idle", n, 0);
    chk("mr_rdata", bus.rdata, 0);
    bus.mem_read_ack = 0; bus.mem_read_avail = 0;
    req(0, 1, 21'h00077, 16'h2222);
    step();
    chk("mr_new_flags", flags(), 8'b1000_0010);
    chk("mr_new_addr", bus.mem_addr, 21'h00077);
    bus.a_req = 0;
    wait_idle("mr_idle");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
